// File: rtl/ps_cu_issue.sv
// ps_cu_issue
// Issue stage for the compute unit. It takes one compute instruction per
// cycle and runs it through a two-stage pipeline: Execute (E), then
// Writeback (W).
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   instr_valid/instr   instruction offer
//   instr_ready         offer accepted when high together with instr_valid
//                       (low on a register read-after-write hazard)
//   bc_wr_req/bc_wr_add bus-connect register-write request and target
//   bc_wr_ack           bus-connect write performed this cycle
//   ps_alu_*, ps_mul_*, ps_shf_*
//                       registered E-stage unit controls
//   ps_xb_raddx/raddy   registered E-stage read addresses (Rx, Ry)
//   ps_xb_wadd          write address (compute Rn, or bc_wr_add)
//   ps_xb_w_cuEn        registered W-stage one-hot compute write select
//                       (bit 0 ALU, bit 1 MUL, bit 2 SHF)
//   ps_xb_w_bcEn        bus-connect write enable
//   alu_ps_*, mul_ps_*, shf_ps_*
//                       unit flags, sampled at the edge that ends W
//   astat_clr           synchronous clear of astat
//   astat               status {sz,sv,mn,mv,av,ac,an,az}
module ps_cu_issue #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int SIGNAL_WIDTH  = 3,
    localparam int IW = 12 + 3 * ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid,
    input  logic [IW-1:0]            instr,
    output logic                     instr_ready,
    input  logic                     bc_wr_req,
    input  logic [ADDRESS_WIDTH-1:0] bc_wr_add,
    output logic                     bc_wr_ack,
    output logic                     ps_alu_en,
    output logic                     ps_alu_log,
    output logic [1:0]               ps_alu_hc,
    output logic [2:0]               ps_alu_sc,
    output logic                     ps_alu_sat,
    output logic                     ps_mul_en,
    output logic                     ps_mul_otreg,
    output logic [3:0]               ps_mul_dtsts,
    output logic [1:0]               ps_mul_cls,
    output logic [1:0]               ps_mul_sc,
    output logic                     ps_shf_en,
    output logic [1:0]               ps_shf_cls,
    output logic [ADDRESS_WIDTH-1:0] ps_xb_raddx,
    output logic [ADDRESS_WIDTH-1:0] ps_xb_raddy,
    output logic [ADDRESS_WIDTH-1:0] ps_xb_wadd,
    output logic [SIGNAL_WIDTH-1:0]  ps_xb_w_cuEn,
    output logic                     ps_xb_w_bcEn,
    input  logic                     alu_ps_az,
    input  logic                     alu_ps_an,
    input  logic                     alu_ps_ac,
    input  logic                     alu_ps_av,
    input  logic                     mul_ps_mv,
    input  logic                     mul_ps_mn,
    input  logic                     shf_ps_sv,
    input  logic                     shf_ps_sz,
    input  logic                     astat_clr,
    output logic [7:0]               astat
);

    typedef enum logic [1:0] {
        U_NOP = 2'b00,
        U_ALU = 2'b01,
        U_MUL = 2'b10,
        U_SHF = 2'b11
    } unit_t;

    // Offered instruction fields
    unit_t                    in_unit;
    logic [9:0]               in_s;
    logic [ADDRESS_WIDTH-1:0] in_rn, in_rx, in_ry;
    logic                     in_writes;
    logic                     accept;
    logic                     unused_s0;

    // Pipeline state; an empty slot is held as U_NOP with no write
    unit_t                    e_unit, w_unit;
    logic                     e_wr, w_wr;
    logic [ADDRESS_WIDTH-1:0] e_rn, w_rn;
    logic [SIGNAL_WIDTH-1:0]  cu_sel;

    always_comb begin
        in_unit   = unit_t'(instr[IW-1 -: 2]);
        in_s      = instr[IW-3 -: 10];
        in_rn     = instr[3*ADDRESS_WIDTH-1 -: ADDRESS_WIDTH];
        in_rx     = instr[2*ADDRESS_WIDTH-1 -: ADDRESS_WIDTH];
        in_ry     = instr[ADDRESS_WIDTH-1:0];
        // MUL with otreg=1 keeps its result inside the multiplier
        in_writes = (in_unit == U_ALU) || (in_unit == U_SHF) ||
                    ((in_unit == U_MUL) && !in_s[9]);
    end

    assign unused_s0 = in_s[0];

    // Read-after-write hazard against a writing instruction in E
    always_comb begin
        instr_ready = 1'b1;
        if (e_wr && (in_unit != U_NOP) && ((in_rx == e_rn) || (in_ry == e_rn)))
            instr_ready = 1'b0;
    end

    assign accept = instr_valid & instr_ready;

    // Compute writeback always has priority over bus-connect writes
    always_comb begin
        ps_xb_w_bcEn = reset & bc_wr_req & ~w_wr;
        bc_wr_ack    = ps_xb_w_bcEn;
        ps_xb_wadd   = '0;
        if (w_wr)
            ps_xb_wadd = w_rn;
        else if (ps_xb_w_bcEn)
            ps_xb_wadd = bc_wr_add;
    end

    always_comb begin
        cu_sel = '0;
        if (e_wr) begin
            case (e_unit)
                U_ALU:   cu_sel[0] = 1'b1;
                U_MUL:   cu_sel[1] = 1'b1;
                U_SHF:   cu_sel[2] = 1'b1;
                default: cu_sel = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_alu_en    <= 1'b0;
            ps_alu_log   <= 1'b0;
            ps_alu_hc    <= '0;
            ps_alu_sc    <= '0;
            ps_alu_sat   <= 1'b0;
            ps_mul_en    <= 1'b0;
            ps_mul_otreg <= 1'b0;
            ps_mul_dtsts <= '0;
            ps_mul_cls   <= '0;
            ps_mul_sc    <= '0;
            ps_shf_en    <= 1'b0;
            ps_shf_cls   <= '0;
            ps_xb_raddx  <= '0;
            ps_xb_raddy  <= '0;
            e_unit       <= U_NOP;
            e_wr         <= 1'b0;
            e_rn         <= '0;
            w_unit       <= U_NOP;
            w_wr         <= 1'b0;
            w_rn         <= '0;
            ps_xb_w_cuEn <= '0;
            astat        <= '0;
        end else begin
            // E stage: a cycle without acceptance becomes a bubble
            ps_alu_en    <= accept && (in_unit == U_ALU);
            ps_alu_log   <= (accept && (in_unit == U_ALU)) ? in_s[9]   : 1'b0;
            ps_alu_hc    <= (accept && (in_unit == U_ALU)) ? in_s[8:7] : 2'b00;
            ps_alu_sc    <= (accept && (in_unit == U_ALU)) ? in_s[6:4] : 3'b000;
            ps_alu_sat   <= (accept && (in_unit == U_ALU)) ? in_s[3]   : 1'b0;
            ps_mul_en    <= accept && (in_unit == U_MUL);
            ps_mul_otreg <= (accept && (in_unit == U_MUL)) ? in_s[9]   : 1'b0;
            ps_mul_dtsts <= (accept && (in_unit == U_MUL)) ? in_s[8:5] : 4'b0000;
            ps_mul_cls   <= (accept && (in_unit == U_MUL)) ? in_s[4:3] : 2'b00;
            ps_mul_sc    <= (accept && (in_unit == U_MUL)) ? in_s[2:1] : 2'b00;
            ps_shf_en    <= accept && (in_unit == U_SHF);
            ps_shf_cls   <= (accept && (in_unit == U_SHF)) ? in_s[9:8] : 2'b00;
            ps_xb_raddx  <= accept ? in_rx : '0;
            ps_xb_raddy  <= accept ? in_ry : '0;
            e_unit       <= accept ? in_unit : U_NOP;
            e_wr         <= accept && in_writes;
            e_rn         <= accept ? in_rn : '0;

            // W stage
            w_unit       <= e_unit;
            w_wr         <= e_wr;
            w_rn         <= e_wr ? e_rn : '0;
            ps_xb_w_cuEn <= cu_sel;

            // Flags are valid throughout W; capture at the edge ending W
            if (astat_clr) begin
                astat <= '0;
            end else begin
                case (w_unit)
                    U_ALU:   astat[3:0] <= {alu_ps_av, alu_ps_ac, alu_ps_an, alu_ps_az};
                    U_MUL:   astat[5:4] <= {mul_ps_mn, mul_ps_mv};
                    U_SHF:   astat[7:6] <= {shf_ps_sz, shf_ps_sv};
                    default: astat <= astat;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps_cu_issue.sv
// Testbench for ps_cu_issue: an instruction-level model (what sits in E and
// W, plus astat) checked against the DUT on every falling edge, and
// directed scenarios with hand-computed literal expectations.
module tb_ps_cu_issue;

    localparam int AW = 4;
    localparam int IW = 12 + 3 * AW;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          instr_valid = 1'b0;
    logic [IW-1:0] instr = '0;
    logic          instr_ready;
    logic          bc_wr_req = 1'b0;
    logic [AW-1:0] bc_wr_add = '0;
    logic          bc_wr_ack;
    logic          ps_alu_en, ps_alu_log, ps_alu_sat;
    logic [1:0]    ps_alu_hc;
    logic [2:0]    ps_alu_sc;
    logic          ps_mul_en, ps_mul_otreg;
    logic [3:0]    ps_mul_dtsts;
    logic [1:0]    ps_mul_cls, ps_mul_sc;
    logic          ps_shf_en;
    logic [1:0]    ps_shf_cls;
    logic [AW-1:0] ps_xb_raddx, ps_xb_raddy, ps_xb_wadd;
    logic [SW-1:0] ps_xb_w_cuEn;
    logic          ps_xb_w_bcEn;
    logic          alu_ps_az = 1'b0, alu_ps_an = 1'b0, alu_ps_ac = 1'b0, alu_ps_av = 1'b0;
    logic          mul_ps_mv = 1'b0, mul_ps_mn = 1'b0, shf_ps_sv = 1'b0, shf_ps_sz = 1'b0;
    logic          astat_clr = 1'b0;
    logic [7:0]    astat;

    int total = 0;
    int bad = 0;

    ps_cu_issue #(.ADDRESS_WIDTH(AW), .SIGNAL_WIDTH(SW)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .bc_wr_req(bc_wr_req), .bc_wr_add(bc_wr_add), .bc_wr_ack(bc_wr_ack),
        .ps_alu_en(ps_alu_en), .ps_alu_log(ps_alu_log), .ps_alu_hc(ps_alu_hc),
        .ps_alu_sc(ps_alu_sc), .ps_alu_sat(ps_alu_sat),
        .ps_mul_en(ps_mul_en), .ps_mul_otreg(ps_mul_otreg), .ps_mul_dtsts(ps_mul_dtsts),
        .ps_mul_cls(ps_mul_cls), .ps_mul_sc(ps_mul_sc),
        .ps_shf_en(ps_shf_en), .ps_shf_cls(ps_shf_cls),
        .ps_xb_raddx(ps_xb_raddx), .ps_xb_raddy(ps_xb_raddy), .ps_xb_wadd(ps_xb_wadd),
        .ps_xb_w_cuEn(ps_xb_w_cuEn), .ps_xb_w_bcEn(ps_xb_w_bcEn),
        .alu_ps_az(alu_ps_az), .alu_ps_an(alu_ps_an), .alu_ps_ac(alu_ps_ac),
        .alu_ps_av(alu_ps_av), .mul_ps_mv(mul_ps_mv), .mul_ps_mn(mul_ps_mn),
        .shf_ps_sv(shf_ps_sv), .shf_ps_sz(shf_ps_sz),
        .astat_clr(astat_clr), .astat(astat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    function automatic logic [IW-1:0] mk(input logic [1:0] u, input logic [9:0] s,
                                         input logic [AW-1:0] rn, input logic [AW-1:0] rx,
                                         input logic [AW-1:0] ry);
        return {u, s, rn, rx, ry};
    endfunction

    function automatic logic [1:0] f_u(input logic [IW-1:0] i);
        return i[IW-1:IW-2];
    endfunction
    function automatic logic [9:0] f_s(input logic [IW-1:0] i);
        return i[IW-3:IW-12];
    endfunction
    function automatic logic [AW-1:0] f_rn(input logic [IW-1:0] i);
        return i[3*AW-1:2*AW];
    endfunction
    function automatic logic [AW-1:0] f_rx(input logic [IW-1:0] i);
        return i[2*AW-1:AW];
    endfunction
    function automatic logic [AW-1:0] f_ry(input logic [IW-1:0] i);
        return i[AW-1:0];
    endfunction

    function automatic logic writes(input logic [IW-1:0] i);
        logic [9:0] s;
        s = f_s(i);
        return (f_u(i) == 2'd1) || (f_u(i) == 2'd3) || ((f_u(i) == 2'd2) && !s[9]);
    endfunction

    function automatic logic [SW-1:0] onehot(input logic [IW-1:0] i);
        if (!writes(i)) return 3'b000;
        if (f_u(i) == 2'd1) return 3'b001;
        if (f_u(i) == 2'd2) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic ready_f(input logic ev, input logic [IW-1:0] e, input logic [IW-1:0] offer);
        if (ev && writes(e) && (f_u(offer) != 2'd0) &&
            ((f_rx(offer) == f_rn(e)) || (f_ry(offer) == f_rn(e))))
            return 1'b0;
        return 1'b1;
    endfunction

    // Expected E outputs, in the order of the DUT concatenation below
    function automatic logic [28:0] exp_e(input logic v, input logic [IW-1:0] i);
        logic [9:0] s;
        logic a, m, h;
        s = f_s(i);
        a = v && (f_u(i) == 2'd1);
        m = v && (f_u(i) == 2'd2);
        h = v && (f_u(i) == 2'd3);
        return {a, a & s[9], a & s[3], a ? s[8:7] : 2'd0, a ? s[6:4] : 3'd0,
                m, m & s[9], m ? s[8:5] : 4'd0, m ? s[4:3] : 2'd0, m ? s[2:1] : 2'd0,
                h, h ? s[9:8] : 2'd0,
                v ? f_rx(i) : 4'd0, v ? f_ry(i) : 4'd0};
    endfunction

    logic          m_e_v = 1'b0, m_w_v = 1'b0;
    logic [IW-1:0] m_e = '0, m_w = '0;
    logic [7:0]    m_astat = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_e_v   <= 1'b0;
            m_w_v   <= 1'b0;
            m_e     <= '0;
            m_w     <= '0;
            m_astat <= '0;
        end else begin
            if (astat_clr)
                m_astat <= '0;
            else if (m_w_v) begin
                case (f_u(m_w))
                    2'd1: m_astat <= {m_astat[7:4], alu_ps_av, alu_ps_ac, alu_ps_an, alu_ps_az};
                    2'd2: m_astat <= {m_astat[7:6], mul_ps_mn, mul_ps_mv, m_astat[3:0]};
                    2'd3: m_astat <= {shf_ps_sz, shf_ps_sv, m_astat[5:0]};
                    default: m_astat <= m_astat;
                endcase
            end
            m_w_v <= m_e_v;
            m_w   <= m_e;
            m_e_v <= instr_valid && ready_f(m_e_v, m_e, instr);
            m_e   <= instr;
        end
    end

    // Compare process: every falling edge, inputs are stable then
    always @(negedge clk) begin
        logic          w_wr, bc;
        logic [AW-1:0] wa;
        w_wr = m_w_v && writes(m_w);
        bc   = reset && bc_wr_req && !w_wr;
        wa   = w_wr ? f_rn(m_w) : (bc ? bc_wr_add : 4'd0);
        chk("e_outputs", {3'b0, ps_alu_en, ps_alu_log, ps_alu_sat, ps_alu_hc, ps_alu_sc,
                          ps_mul_en, ps_mul_otreg, ps_mul_dtsts, ps_mul_cls, ps_mul_sc,
                          ps_shf_en, ps_shf_cls, ps_xb_raddx, ps_xb_raddy},
            {3'b0, exp_e(m_e_v, m_e)});
        chk("w_cuEn", 32'(ps_xb_w_cuEn), 32'(m_w_v ? onehot(m_w) : 3'b000));
        chk("wadd", 32'(ps_xb_wadd), 32'(wa));
        chk("bcEn_ack", {30'b0, ps_xb_w_bcEn, bc_wr_ack}, {30'b0, bc, bc});
        chk("instr_ready", 32'(instr_ready), 32'(ready_f(m_e_v, m_e, instr)));
        chk("astat", 32'(astat), 32'(m_astat));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        // ALU decode and writeback, az flag into astat
        instr = mk(2'd1, 10'b1_10_011_1_000, 4'd5, 4'd1, 4'd2);
        instr_valid = 1'b1;
        alu_ps_az = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr = '0;
        chk("lit_alu_en", 32'(ps_alu_en), 32'd1);
        chk("lit_alu_fields", {25'b0, ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat},
            {25'b0, 1'b1, 2'd2, 3'd3, 1'b1});
        chk("lit_radd", {24'b0, ps_xb_raddx, ps_xb_raddy}, 32'h12);
        tick();
        chk("lit_alu_cuEn", 32'(ps_xb_w_cuEn), 32'b001);
        chk("lit_alu_wadd", 32'(ps_xb_wadd), 32'd5);
        tick();
        chk("lit_astat_az", 32'(astat), 32'h01);

        // Reset with MUL in E and ALU in W
        instr = mk(2'd1, 10'd0, 4'd8, 4'd0, 4'd0);
        instr_valid = 1'b1;
        tick();
        instr = mk(2'd2, 10'd0, 4'd9, 4'd1, 4'd1);
        tick();
        instr_valid = 1'b0;
        instr = '0;
        chk("lit_pre_rst_mul", 32'(ps_mul_en), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("lit_rst_enables", {29'b0, ps_alu_en, ps_mul_en, ps_shf_en}, 32'd0);
        chk("lit_rst_cuEn", 32'(ps_xb_w_cuEn), 32'd0);
        chk("lit_rst_astat", 32'(astat), 32'd0);
        chk("lit_rst_ready", 32'(instr_ready), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("lit_post_rst_cuEn", 32'(ps_xb_w_cuEn), 32'd0);
        chk("lit_post_rst_astat", 32'(astat), 32'd0);
        alu_ps_az = 1'b0;

        // RAW hazard: ALU writes R3, SHF reads Rx=3
        instr = mk(2'd1, 10'd0, 4'd3, 4'd0, 4'd0);
        instr_valid = 1'b1;
        tick();
        instr = mk(2'd3, 10'b01_0000_0000, 4'd7, 4'd3, 4'd0);
        #1;
        chk("lit_hazard_stall", 32'(instr_ready), 32'd0);
        tick();
        chk("lit_hazard_release", 32'(instr_ready), 32'd1);
        chk("lit_bubble_shf", 32'(ps_shf_en), 32'd0);
        tick();
        instr_valid = 1'b0;
        instr = '0;
        chk("lit_shf_e", {29'b0, ps_shf_en, ps_shf_cls}, 32'b101);
        tick();
        chk("lit_shf_cuEn", 32'(ps_xb_w_cuEn), 32'b100);
        chk("lit_shf_wadd", 32'(ps_xb_wadd), 32'd7);

        // Bus-connect arbitration against ALU writeback
        instr = mk(2'd1, 10'd0, 4'd4, 4'd0, 4'd0);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr = '0;
        tick();
        bc_wr_req = 1'b1;
        bc_wr_add = 4'd9;
        #1;
        chk("lit_bc_blocked", {30'b0, bc_wr_ack, ps_xb_w_bcEn}, 32'd0);
        chk("lit_bc_blocked_wadd", 32'(ps_xb_wadd), 32'd4);
        tick();
        chk("lit_bc_granted", {30'b0, bc_wr_ack, ps_xb_w_bcEn}, 32'b11);
        chk("lit_bc_wadd", 32'(ps_xb_wadd), 32'd9);
        bc_wr_req = 1'b0;
        bc_wr_add = '0;

        // MUL otreg=1: no write, but mv/mn captured; then clear wins
        mul_ps_mv = 1'b1;
        mul_ps_mn = 1'b1;
        instr = mk(2'd2, 10'b1_0000_00_00_0, 4'd6, 4'd0, 4'd0);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        chk("lit_mul_otreg_cuEn", 32'(ps_xb_w_cuEn), 32'd0);
        tick();
        chk("lit_mul_astat", 32'(astat), 32'h30);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr = '0;
        tick();
        astat_clr = 1'b1;
        tick();
        astat_clr = 1'b0;
        chk("lit_astat_clr", 32'(astat), 32'd0);
        mul_ps_mv = 1'b0;
        mul_ps_mn = 1'b0;

        // Back-to-back independent ALU, MUL, SHF, NOP
        instr_valid = 1'b1;
        instr = mk(2'd1, 10'd0, 4'd10, 4'd1, 4'd2);
        #1 chk("lit_b2b_ready_alu", 32'(instr_ready), 32'd1);
        tick();
        instr = mk(2'd2, 10'b0_1010_01_10_0, 4'd11, 4'd3, 4'd4);
        #1 chk("lit_b2b_ready_mul", 32'(instr_ready), 32'd1);
        tick();
        chk("lit_b2b_w_alu", 32'(ps_xb_w_cuEn), 32'b001);
        chk("lit_mul_fields", {22'b0, ps_mul_otreg, ps_mul_dtsts, ps_mul_cls, ps_mul_sc},
            {22'b0, 1'b0, 4'b1010, 2'b01, 2'b10});
        instr = mk(2'd3, 10'd0, 4'd12, 4'd5, 4'd6);
        #1 chk("lit_b2b_ready_shf", 32'(instr_ready), 32'd1);
        tick();
        chk("lit_b2b_w_mul", 32'(ps_xb_w_cuEn), 32'b010);
        instr = '0;
        #1 chk("lit_b2b_ready_nop", 32'(instr_ready), 32'd1);
        tick();
        chk("lit_b2b_w_shf", 32'(ps_xb_w_cuEn), 32'b100);
        instr_valid = 1'b0;
        tick();
        chk("lit_b2b_w_nop", 32'(ps_xb_w_cuEn), 32'b000);

        tick();
        tick();
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps_cu_issue.md
# ps_cu_issue

Program-sequencer-side issue stage for the compute unit. Accepts one compute instruction word per cycle, decodes it into the ALU/multiplier/shifter control fields and crossbar read/write addresses the compute unit consumes, and sequences a two-stage pipeline: Execute (E), then Writeback (W). It inserts a one-cycle bubble on register read-after-write hazards, arbitrates bus-connect register writes against compute writeback, and collects unit flags into an 8-bit sticky-free status register `astat`.

## Interface
- `ADDRESS_WIDTH`, 4: register address width. Instruction width is `IW = 12 + 3*ADDRESS_WIDTH` (default 24).
- `SIGNAL_WIDTH`, 3: width of the compute-write one-hot. Bit 0 is ALU, bit 1 is MUL, bit 2 is SHF.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction offered.
- `instr`  in  IW  instruction word.
- `instr_ready`  out  1  instruction accepted at this edge when it is high together with `instr_valid`.
- `bc_wr_req`  in  1  bus-connect register-write request.
- `bc_wr_add`  in  ADDRESS_WIDTH  target register for the bus-connect write.
- `bc_wr_ack`  out  1  bus-connect write performed this cycle.
- `ps_alu_en`, `ps_alu_log`, `ps_alu_sat`  out  1 each  ALU controls.
- `ps_alu_hc`  out  2  ALU control.
- `ps_alu_sc`  out  3  ALU control.
- `ps_mul_en`, `ps_mul_otreg`  out  1 each  multiplier controls.
- `ps_mul_dtsts`  out  4  multiplier control.
- `ps_mul_cls`, `ps_mul_sc`  out  2 each  multiplier controls.
- `ps_shf_en`  out  1  shifter enable.
- `ps_shf_cls`  out  2  shifter control.
- `ps_xb_raddx`, `ps_xb_raddy`, `ps_xb_wadd`  out  ADDRESS_WIDTH each  crossbar/register-file addresses.
- `ps_xb_w_cuEn`  out  SIGNAL_WIDTH  one-hot compute writeback select.
- `ps_xb_w_bcEn`  out  1  bus-connect write enable.
- `alu_ps_az`, `alu_ps_an`, `alu_ps_ac`, `alu_ps_av`, `mul_ps_mv`, `mul_ps_mn`, `shf_ps_sv`, `shf_ps_sz`  in  1 each  unit flags.
- `astat_clr`  in  1  synchronous clear of `astat`.
- `astat`  out  8  status register, bit order {sz,sv,mn,mv,av,ac,an,az} (bit 7 down to bit 0).

## Operation
- Instruction fields:
  - `[IW-1:IW-2]` unit: 00 NOP, 01 ALU, 10 MUL, 11 SHF.
  - `[IW-3:IW-12]` sub-field `s[9:0]`.
  - Then Rn, Rx, Ry, each ADDRESS_WIDTH bits; Ry occupies the LSBs.
- Sub-field mapping:
  - ALU: log=s[9], hc=s[8:7], sc=s[6:4], sat=s[3].
  - MUL: otreg=s[9], dtsts=s[8:5], cls=s[4:3], sc=s[2:1].
  - SHF: cls=s[9:8].
  - Unused bits are ignored.
- E stage (registered outputs):
  - The enable of the selected unit is 1 and its sub-fields are driven.
  - `ps_xb_raddx`=Rx, `ps_xb_raddy`=Ry.
  - All other unit enables and all sub-field outputs are 0.
  - With no instruction in E, every E output is 0.
- W stage (registered state):
  - A writing instruction (ALU, SHF, or MUL with otreg=0) drives `ps_xb_w_cuEn` one-hot for its unit and `ps_xb_wadd`=Rn.
  - NOP and MUL with otreg=1 drive `ps_xb_w_cuEn`=0.
- `astat` update, at the clock edge ending W:
  - ALU loads bits [3:0] from the az/an/ac/av inputs.
  - MUL loads [5:4] from mv/mn, including when otreg=1.
  - SHF loads [7:6] from sv/sz.
  - Bits not owned by the unit hold. NOP updates nothing.
  - `astat_clr` forces `astat` to 0 and wins over a simultaneous W update.
- Hazard:
  - `instr_ready` = 0 when a writing instruction is in E and the offered `instr` has Rx==Rn(E) or Ry==Rn(E). Otherwise `instr_ready`=1.
  - `instr_ready` is combinational from `instr` and E state.
  - A NOP offer never stalls.
- Bus-connect arbitration (combinational):
  - `ps_xb_w_bcEn` = `bc_wr_ack` = `bc_wr_req` & ~(W writing).
  - When `ps_xb_w_bcEn` is 1, `ps_xb_wadd`=`bc_wr_add`.
  - Compute writeback always wins. The requester holds its request until acked.
- Bubbles: a cycle with no accepted instruction leaves E empty in the next cycle, and that empty slot moves to W in the cycle after.

## Timing
- Accept at edge k: E occupies cycle k+1 and W occupies cycle k+2. The register file writes at the edge ending k+2.
- Units register at the edge ending E, so their data and flags are valid throughout W.
- Throughput is 1 instruction per cycle without hazards. A dependent back-to-back instruction costs exactly 1 bubble cycle.
- Reset asserted (low):
  - All outputs are 0 except `instr_ready`=1.
  - `astat`=0.
  - E and W are emptied immediately.
- Reset mid-operation: in-flight instructions are dropped and produce no register write and no `astat` update. The first acceptance is possible at the first edge after reset releases.

## Test plan
- Reset with a MUL in E and an ALU in W: all enables 0, `ps_xb_w_cuEn`=0, `astat`=0x00, `instr_ready`=1; after release, no write occurs.
- ALU with s=10'b1_10_011_1_000, Rn=5, Rx=1, Ry=2, accepted at edge 0:
  - Cycle 1: `ps_alu_en`=1, log=1, hc=2, sc=3, sat=1, raddx=1, raddy=2.
  - Cycle 2: `ps_xb_w_cuEn`=3'b001, wadd=5.
  - With az=1, `astat`=0x01 at edge 2.
- ALU writing R3, followed by SHF reading Rx=3: `instr_ready`=0 for one cycle, then the SHF is accepted; SHF E lands in cycle 3 and W in cycle 4, with `ps_xb_w_cuEn`=3'b100.
- `bc_wr_req`=1, `bc_wr_add`=9 during an ALU W:
  - `bc_wr_ack`=0 and wadd equals the ALU Rn.
  - Next cycle (W empty): `ps_xb_w_bcEn`=1, wadd=9, ack=1.
- MUL with otreg=1, mv=1, mn=1 in W: `ps_xb_w_cuEn`=0 and `astat`[5:4]=2'b11. With `astat_clr`=1 in the same W cycle, `astat`=0x00.
- Back-to-back independent ALU, MUL, SHF, NOP: no stalls; W one-hots 001, 010, 100, 000 in consecutive cycles.
